deinterleaver_ctrl: RTL

- Sequencer for the 802.11a receive deinterleaver. Owns an external two-bank (ping-pong) 1-bit symbol RAM.
- Generates permuted write addresses for each incoming demapped bit and linear read addresses toward the Viterbi decoder.
- Configured per packet from the decoded SIGNAL field (RATE, symbol count). Sits between the demapper and the depuncturer/Viterbi.

---
 rtl/deint_pkg.sv | 51 +++++
 rtl/deint_addr_gen.sv | 96 +++++++++
 rtl/deinterleaver_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/deint_pkg.sv
// ---------------------------------------------------------------------------
// deint_pkg
// Shared definitions for the 802.11a receive deinterleaver controller:
//   - RATE field codes (rate_e)
//   - per-rate coded-bits-per-symbol / bits-per-subcarrier lookup
//   - controller state encoding (legacy-compatible localparam constants)
//   - MAX_NCBPS, the largest symbol the RAM banks must hold
// ---------------------------------------------------------------------------
package deint_pkg;

    localparam int MAX_NCBPS = 288;
    localparam int NCBPS_W   = 9;   // holds MAX_NCBPS
    localparam int BPSC_W    = 3;   // holds N_BPSC up to 6

    typedef enum logic [3:0] {
        RATE_6  = 4'b1101,
        RATE_9  = 4'b1111,
        RATE_12 = 4'b0101,
        RATE_18 = 4'b0111,
        RATE_24 = 4'b1001,
        RATE_36 = 4'b1011,
        RATE_48 = 4'b0001,
        RATE_54 = 4'b0011
    } rate_e;

    typedef struct packed {
        logic               valid;
        logic [NCBPS_W-1:0] ncbps;
        logic [BPSC_W-1:0]  bpsc;
    } rate_cfg_t;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WRITE = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    // Map a RATE code to N_CBPS / N_BPSC; unknown codes return valid=0.
    function automatic rate_cfg_t rate_lookup(input logic [3:0] rate);
        rate_cfg_t cfg;
        cfg = '{valid: 1'b0, ncbps: '0, bpsc: '0};
        case (rate)
            RATE_6,  RATE_9:  cfg = '{valid: 1'b1, ncbps: 9'd48,  bpsc: 3'd1};
            RATE_12, RATE_18: cfg = '{valid: 1'b1, ncbps: 9'd96,  bpsc: 3'd2};
            RATE_24, RATE_36: cfg = '{valid: 1'b1, ncbps: 9'd192, bpsc: 3'd4};
            RATE_48, RATE_54: cfg = '{valid: 1'b1, ncbps: 9'd288, bpsc: 3'd6};
            default:          cfg = '{valid: 1'b0, ncbps: '0,     bpsc: '0};
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/deint_addr_gen.sv
// ---------------------------------------------------------------------------
// deint_addr_gen
// Produces the deinterleaved RAM position k for received bit index j, using
// only counters (no dividers or multipliers).
//
// With c = N_CBPS/16 and s = max(N_BPSC/2,1), c is always a multiple of s, so
// the s-group containing j lies in one row of c and the second permutation
// only rotates j inside that group.  The first inverse permutation then
// reduces to k = 16*(i mod c) + floor(i/c) = {i mod c, floor(j/c)}.
//
// Ports:
//   Clock, Reset  clock, asynchronous active-high reset
//   clear         restart at j=0 (new packet)
//   advance       current bit written, step to j+1 (wraps after last)
//   identity      output k=j instead of the permutation
//   ncbps, bpsc   symbol configuration
//   addr          k for the current j (combinational)
//   last          current j is N_CBPS-1
// ---------------------------------------------------------------------------
module deint_addr_gen
    import deint_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              clear,
    input  logic              advance,
    input  logic              identity,
    input  logic [ADDR_W-1:0] ncbps,
    input  logic [BPSC_W-1:0] bpsc,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] cols;     // c = N_CBPS/16
    logic [1:0]        s;
    logic [ADDR_W-1:0] j;
    logic [1:0]        jm_s;     // j mod s
    logic [1:0]        qm_s;     // floor(j/c) mod s
    logic [4:0]        jc_r;     // j mod c
    logic [3:0]        jc_q;     // floor(j/c)
    logic [2:0]        rot_sum;
    logic [2:0]        rot;
    logic [4:0]        i_r;      // i mod c
    logic              row_end;

    assign cols = ncbps >> 4;

    always_comb begin
        s = 2'd1;
        case (bpsc)
            3'd4:    s = 2'd2;
            3'd6:    s = 2'd3;
            default: s = 2'd1;
        endcase
    end

    // (j + floor(16j/N)) mod s, built from the two residues already held.
    assign rot_sum = {1'b0, jm_s} + {1'b0, qm_s};
    assign rot     = (rot_sum >= {1'b0, s}) ? (rot_sum - {1'b0, s}) : rot_sum;
    assign i_r     = jc_r - {3'b000, jm_s} + {3'b000, rot[1:0]};

    assign last    = (j == ncbps - ADDR_W'(1));
    assign row_end = (ADDR_W'(jc_r) == cols - ADDR_W'(1));

    // jc_q < 16, so concatenation is 16*(i mod c) + floor(i/c).
    assign addr = identity ? j : ADDR_W'({i_r, jc_q});

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            j    <= '0;
            jm_s <= '0;
            qm_s <= '0;
            jc_r <= '0;
            jc_q <= '0;
        end else if (clear || (advance && last)) begin
            j    <= '0;
            jm_s <= '0;
            qm_s <= '0;
            jc_r <= '0;
            jc_q <= '0;
        end else if (advance) begin
            j    <= j + ADDR_W'(1);
            jm_s <= (jm_s == s - 2'd1) ? 2'd0 : jm_s + 2'd1;
            if (row_end) begin
                jc_r <= '0;
                jc_q <= jc_q + 4'd1;
                qm_s <= (qm_s == s - 2'd1) ? 2'd0 : qm_s + 2'd1;
            end else begin
                jc_r <= jc_r + 5'd1;
            end
        end
    end

endmodule

// File: rtl/deinterleaver_ctrl.sv
// ---------------------------------------------------------------------------
// deinterleaver_ctrl
// Sequencer for the 802.11a receive deinterleaver.  Owns an external
// two-bank (ping-pong) 1-bit symbol RAM: demapped bits are written at their
// deinterleaved position, full banks are read out linearly to the Viterbi.
//
// Optional build macro DEINT_BYPASS_EN adds input Bypass (latched at Start);
// when set, write addresses are the identity j for RAM path debug.
//
// Ports:
//   Clock, Reset       clock, asynchronous active-high reset
//   Start, Rate,       packet start pulse and SIGNAL field config
//   NumSym
//   Bypass             (DEINT_BYPASS_EN only) identity write addressing
//   InValid/InReady    demapper bit handshake
//   WrEn/WrBank/WrAddr RAM write port
//   RdEn/RdBank/RdAddr RAM synchronous read port
//   OutValid/OutReady  RAM read data handshake toward the Viterbi
//   SymbolDone         pulse as a symbol's last bit is accepted
//   Busy, Error        status (Error sticky until next Start)
// ---------------------------------------------------------------------------
module deinterleaver_ctrl
    import deint_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int NSYM_W = 12
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [3:0]        Rate,
    input  logic [NSYM_W-1:0] NumSym,
`ifdef DEINT_BYPASS_EN
    input  logic              Bypass,
`endif
    input  logic              InValid,
    output logic              InReady,
    output logic              WrEn,
    output logic              WrBank,
    output logic [ADDR_W-1:0] WrAddr,
    output logic              RdEn,
    output logic              RdBank,
    output logic [ADDR_W-1:0] RdAddr,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              SymbolDone,
    output logic              Busy,
    output logic              Error
);

    state_t            state;
    rate_cfg_t         cfg;
    logic              cfg_ok;
    logic              accept;

    logic [ADDR_W-1:0] ncbps;
    logic [BPSC_W-1:0] bpsc;
    logic [NSYM_W-1:0] nsym;
    logic [NSYM_W-1:0] wr_syms;
    logic [NSYM_W-1:0] rd_syms;
    logic              bypass_q;
    logic              error_q;

    logic [1:0]        full;
    logic [1:0]        full_set;
    logic [1:0]        full_clr;
    logic              wr_bank;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic              out_valid;
    logic              rd_tail;    // last address of the bank already issued

    logic              in_ready;
    logic              wr_en;
    logic              wr_last;
    logic              wr_sym_end;
    logic              rd_en;
    logic              rd_last_addr;
    logic              sym_done;

    assign cfg    = rate_lookup(Rate);
    assign cfg_ok = cfg.valid && (NumSym != '0);
    assign accept = Start && (state == ST_IDLE) && cfg_ok;

    assign in_ready   = (state == ST_WRITE) && !full[wr_bank];
    assign wr_en      = InValid && in_ready;
    assign wr_sym_end = wr_en && wr_last;

    // No new read for this bank once its final address is out; the next
    // bank starts after the last bit has been accepted and RdBank flips.
    assign rd_last_addr = (rd_addr == ncbps - ADDR_W'(1));
    assign rd_en        = full[rd_bank] && !rd_tail && (!out_valid || OutReady);
    assign sym_done     = out_valid && OutReady && rd_tail;

    // Write and read always target different banks: one is empty, one full.
    assign full_set = wr_sym_end ? (2'b01 << wr_bank) : 2'b00;
    assign full_clr = sym_done   ? (2'b01 << rd_bank) : 2'b00;

    deint_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .Clock    (Clock),
        .Reset    (Reset),
        .clear    (accept),
        .advance  (wr_en),
        .identity (bypass_q),
        .ncbps    (ncbps),
        .bpsc     (bpsc),
        .addr     (WrAddr),
        .last     (wr_last)
    );

    // Control FSM and per-packet configuration
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= ST_IDLE;
            ncbps   <= '0;
            bpsc    <= '0;
            nsym    <= '0;
            error_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        if (cfg_ok) begin
                            state   <= ST_WRITE;
                            ncbps   <= ADDR_W'(cfg.ncbps);
                            bpsc    <= cfg.bpsc;
                            nsym    <= NumSym;
                            error_q <= 1'b0;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (wr_sym_end && (wr_syms == nsym - NSYM_W'(1)))
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (sym_done && (rd_syms == nsym - NSYM_W'(1)))
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DEINT_BYPASS_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            bypass_q <= 1'b0;
        else if (accept)
            bypass_q <= Bypass;
    end
`else
    assign bypass_q = 1'b0;
`endif

    // Bank occupancy, bank pointers and symbol counters
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_syms <= '0;
            rd_syms <= '0;
        end else if (accept) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_syms <= '0;
            rd_syms <= '0;
        end else begin
            full <= (full | full_set) & ~full_clr;
            if (wr_sym_end) begin
                wr_bank <= ~wr_bank;
                wr_syms <= wr_syms + NSYM_W'(1);
            end
            if (sym_done) begin
                rd_bank <= ~rd_bank;
                rd_syms <= rd_syms + NSYM_W'(1);
            end
        end
    end

    // Read address and output valid (one-cycle RAM latency)
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_addr   <= '0;
            rd_tail   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (rd_en)
                rd_addr <= rd_last_addr ? '0 : rd_addr + ADDR_W'(1);

            if (rd_en && rd_last_addr)
                rd_tail <= 1'b1;
            else if (sym_done)
                rd_tail <= 1'b0;

            if (rd_en)
                out_valid <= 1'b1;
            else if (OutReady)
                out_valid <= 1'b0;
        end
    end

    assign InReady    = in_ready;
    assign WrEn       = wr_en;
    assign WrBank     = wr_bank;
    assign RdEn       = rd_en;
    assign RdBank     = rd_bank;
    assign RdAddr     = rd_addr;
    assign OutValid   = out_valid;
    assign SymbolDone = sym_done;
    assign Busy       = (state != ST_IDLE);
    assign Error      = error_q;

endmodule
